// File: rtl/sequence_detector.sv
// sequence_detector: serial pattern detector with saturating match counter.
//   clk       in  system clock, rising edge
//   rst       in  asynchronous active-high reset
//   din       in  serial data bit
//   din_vld   in  qualifies din
//   clr       in  synchronous clear, priority over din_vld
//   match     out one-cycle pulse after the bit completing PATTERN
//   match_cnt out saturating match count
//   hist      out last PAT_LEN accepted bits, bit 0 newest
//   filled    out PAT_LEN bits accepted since reset/clr/restart
// Define SEQ_DET_NONOVERLAP_EN to restart detection after every match.
module sequence_detector #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter int                 CNT_W   = 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               din,
   input  logic               din_vld,
   input  logic               clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic [PAT_LEN-1:0] hist,
   output logic               filled
);
   localparam int FW = $clog2(PAT_LEN + 1);
   typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_t;
   state_t             r_state, w_state_nx;
   logic [FW-1:0]      r_fill, w_fill_nx;
   logic [PAT_LEN-1:0] r_hist, w_hist_nx, w_shift;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
   logic               r_match, w_match_nx, w_hit, w_restart;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= EMPTY;
         r_fill  <= '0;
         r_hist  <= '0;
         r_cnt   <= '0;
         r_match <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_fill  <= w_fill_nx;
         r_hist  <= w_hist_nx;
         r_cnt   <= w_cnt_nx;
         r_match <= w_match_nx;
      end
   always_comb begin
      w_shift = {r_hist[PAT_LEN-2:0], din};
      // ARMED guarantees PAT_LEN-1 valid bits in hist, so din completes a full window
      w_hit = din_vld && r_state == ARMED && w_shift == PATTERN;
`ifdef SEQ_DET_NONOVERLAP_EN
      w_restart = w_hit;
`else
      w_restart = 1'b0;
`endif
      w_fill_nx  = (clr || w_restart) ? '0
                 : (din_vld && r_fill != FW'(PAT_LEN)) ? r_fill + FW'(1) : r_fill;
      w_hist_nx  = (clr || w_restart) ? '0 : din_vld ? w_shift : r_hist;
      w_cnt_nx   = clr ? '0 : (w_hit && r_cnt != '1) ? r_cnt + CNT_W'(1) : r_cnt;
      w_match_nx = !clr && w_hit;
      w_state_nx = (clr || w_restart) ? EMPTY
                 : (!din_vld || r_state == ARMED) ? r_state
                 : (w_fill_nx >= FW'(PAT_LEN - 1)) ? ARMED : FILLING;
   end
   always_comb begin
      match     = r_match;
      match_cnt = r_cnt;
      hist      = r_hist;
      filled    = r_fill == FW'(PAT_LEN);
   end
endmodule

// File: tb/tb_sequence_detector.sv
// tb_sequence_detector: random and directed checks against a queue-based model.
module tb_sequence_detector;
   localparam int             PAT_LEN = 4;
   localparam logic [3:0]     PATTERN = 4'b1011;
   logic       clk, rst, din, din_vld, clr;
   logic       match, match2, filled, filled2;
   logic [7:0] cnt;
   logic [1:0] cnt2;
   logic [3:0] hist, hist2;
   int         n_chk, n_fail, n_pulse2;
   bit         q[$];
   int         m_cnt, m_cnt2;
   bit         m_match;
   sequence_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
      .match(match), .match_cnt(cnt), .hist(hist), .filled(filled));
   sequence_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
      .match(match2), .match_cnt(cnt2), .hist(hist2), .filled(filled2));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic int hist_val();
      int h = 0;
      foreach (q[i]) h = h * 2 + int'(q[i]);
      return h;
   endfunction
   function automatic int win_val();
      return (q.size() == PAT_LEN) ? hist_val() : -1;
   endfunction
   task automatic check_all();
      check("match", match, m_match);
      check("match_cnt", cnt, m_cnt);
      check("hist", hist, hist_val());
      check("filled", filled, q.size() == PAT_LEN);
      check("match2", match2, m_match);
      check("match_cnt2", cnt2, m_cnt2);
      check("hist2", hist2, hist_val());
      check("filled2", filled2, q.size() == PAT_LEN);
   endtask
   task automatic model_edge();
      m_match = 0;
      if (clr) begin
         q.delete();
         m_cnt = 0;
         m_cnt2 = 0;
      end else if (din_vld) begin
         q.push_back(din);
         if (q.size() > PAT_LEN) void'(q.pop_front());
         if (win_val() == int'(PATTERN)) begin
            m_match = 1;
            m_cnt  = (m_cnt == 255) ? 255 : m_cnt + 1;
            m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
`ifdef SEQ_DET_NONOVERLAP_EN
            q.delete();
`endif
         end
      end
   endtask
   task automatic step(input logic v, input logic d, input logic c);
      din_vld = v;
      din = d;
      clr = c;
      @(posedge clk);
      model_edge();
      #1;
      if (match2) n_pulse2++;
      check_all();
   endtask
   task automatic do_rst();
      rst = 1'b1;
      #1;
      q.delete();
      m_cnt = 0;
      m_cnt2 = 0;
      m_match = 0;
      check_all();
      #1;
      rst = 1'b0;
   endtask
   task automatic send(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
   endtask
   initial begin
      n_chk = 0;
      n_fail = 0;
      n_pulse2 = 0;
      rst = 1'b1;
      din = 1'b0;
      din_vld = 1'b0;
      clr = 1'b0;
      #2;
      do_rst();
      send(16'b1011, 4);
      check("req27_match_at_4th", match, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check("req27_match_drop", match, 1'b0);
      check("req27_cnt", cnt, 8'd1);
      check("req27_hist", hist, 4'b1011);
      do_rst();
      send(16'b1011011, 7);
`ifdef SEQ_DET_NONOVERLAP_EN
      check("req28_cnt", cnt, 8'd1);
`else
      check("req28_cnt", cnt, 8'd2);
`endif
      do_rst();
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("req29_match", match, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      check("req29_gap", match, 1'b0);
      check("req29_cnt", cnt, 8'd1);
      do_rst();
      n_pulse2 = 0;
      for (int k = 0; k < 5; k++) send(16'b1011, 4);
      check("req30_cnt2_sat", cnt2, 2'd3);
      check("req30_pulses", n_pulse2, 5);
      check("req30_cnt8", cnt, 8'd5);
      do_rst();
      send(16'b101, 3);
      step(1'b1, 1'b1, 1'b1);
      check("req31_match", match, 1'b0);
      check("req31_cnt", cnt, 8'd0);
      check("req31_filled", filled, 1'b0);
      send(16'b101, 3);
      check("req31_empty_no_match", match, 1'b0);
      do_rst();
      send(16'b101, 3);
      do_rst();
      step(1'b1, 1'b1, 1'b0);
      check("req32_no_match", match, 1'b0);
      send(16'b1011, 4);
      check("req32_match", match, 1'b1);
      do_rst();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(99) == 0) do_rst();
         step($urandom_range(3) != 0, 1'($urandom), $urandom_range(29) == 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
